// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage. Selects the WB result, commits it to the
// architectural register file, serves the two decode read ports with a
// same-cycle write-through bypass, and counts retired instructions.
// Optional feature macro: WB_TRACE_EN (simulation trace of retiring
// instructions; when undefined no display statements are compiled).
module wb_regfile #(
  parameter int DW    = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validW,
  input  logic [31:0]      instrW,
  input  logic             regwriteW,
  input  logic             memtoregW,
  input  logic [DW-1:0]    aluoutW,
  input  logic [DW-1:0]    readdataW,
  input  logic [AW-1:0]    writeregW,
  input  logic [AW-1:0]    ra1D,
  input  logic [AW-1:0]    ra2D,
  output logic [DW-1:0]    rd1D,
  output logic [DW-1:0]    rd2D,
  output logic [DW-1:0]    resultW,
  output logic [CNT_W-1:0] retired_cnt
);

  logic [DW-1:0]    rf_r [NREGS];
  logic [CNT_W-1:0] cnt_r;
  logic             we_s;

  // Result select is purely combinational so forwarding sees it immediately.
  assign resultW = memtoregW ? readdataW : aluoutW;

  // Register 0 is hard-wired to zero, so writes aimed at it are dropped here.
  assign we_s = validW & regwriteW & (writeregW != {AW{1'b0}});

  assign retired_cnt = cnt_r;

  // Register file storage: cleared asynchronously, written on a real WB write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_r[i] <= {DW{1'b0}};
      end
    end else if (we_s) begin
      rf_r[writeregW] <= resultW;
    end
  end

  // Retired-instruction counter: every non-bubble counts, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (validW) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Read port 1: zero register, then same-cycle bypass, then stored value.
  always_comb begin
    rd1D = {DW{1'b0}};
    if (reset) begin
      rd1D = {DW{1'b0}};
    end else if (ra1D == {AW{1'b0}}) begin
      rd1D = {DW{1'b0}};
    end else if (we_s && (writeregW == ra1D)) begin
      rd1D = resultW;
    end else begin
      rd1D = rf_r[ra1D];
    end
  end

  // Read port 2: same priority as port 1 so both ports always agree.
  always_comb begin
    rd2D = {DW{1'b0}};
    if (reset) begin
      rd2D = {DW{1'b0}};
    end else if (ra2D == {AW{1'b0}}) begin
      rd2D = {DW{1'b0}};
    end else if (we_s && (writeregW == ra2D)) begin
      rd2D = resultW;
    end else begin
      rd2D = rf_r[ra2D];
    end
  end

`ifdef WB_TRACE_EN
  // Trace each retiring instruction; the counter shown is the pre-retire value.
  always @(posedge clk) begin
    if (!reset && validW) begin
      if (we_s) begin
        $display("[WB] instr=%h cnt=%0d x%0d <= %h", instrW, cnt_r, writeregW, resultW);
      end else begin
        $display("[WB] instr=%h cnt=%0d", instrW, cnt_r);
      end
    end
  end
`else
  // The instruction word only feeds the trace; fold it away otherwise.
  logic unused_instr_s;
  assign unused_instr_s = ^instrW;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the stimulus process pushes expected
// output values into a queue; a monitor on the falling edge pops and compares.
module tb_wb_regfile;

  localparam int SEL_RD1   = 0;
  localparam int SEL_RD2   = 1;
  localparam int SEL_RES   = 2;
  localparam int SEL_CNT   = 3;
  localparam int SEL_SMALL = 4;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        validW, regwriteW, memtoregW;
  logic [31:0] instrW, aluoutW, readdataW;
  logic [4:0]  writeregW, ra1D, ra2D;
  logic [31:0] rd1D, rd2D, resultW, retired_cnt;

  logic        validS;
  logic [31:0] s_rd1, s_rd2, s_res;
  logic [3:0]  s_cnt;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  wb_regfile u_dut (
    .clk(clk), .reset(reset), .validW(validW), .instrW(instrW),
    .regwriteW(regwriteW), .memtoregW(memtoregW), .aluoutW(aluoutW),
    .readdataW(readdataW), .writeregW(writeregW), .ra1D(ra1D), .ra2D(ra2D),
    .rd1D(rd1D), .rd2D(rd2D), .resultW(resultW), .retired_cnt(retired_cnt)
  );

  wb_regfile #(.CNT_W(4)) u_small (
    .clk(clk), .reset(reset), .validW(validS), .instrW(32'h0),
    .regwriteW(1'b0), .memtoregW(1'b0), .aluoutW(32'h0),
    .readdataW(32'h0), .writeregW(5'd0), .ra1D(5'd0), .ra2D(5'd0),
    .rd1D(s_rd1), .rd2D(s_rd2), .resultW(s_res), .retired_cnt(s_cnt)
  );

  // Monitor: compare every pending expectation against the live outputs.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        SEL_RD1: act = rd1D;
        SEL_RD2: act = rd2D;
        SEL_RES: act = resultW;
        SEL_CNT: act = retired_cnt;
        default: act = {28'h0, s_cnt};
      endcase
      tests++;
      if (act !== e.exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic expect_val(input int sel, input logic [31:0] v, input string n);
    exp_t e;
    e.sel = sel; e.exp = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    validW = 1'b0; regwriteW = 1'b0; memtoregW = 1'b0;
    aluoutW = 32'h0; readdataW = 32'h0; writeregW = 5'd0;
    instrW = 32'h0000_0013;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    validW = 1'b1; regwriteW = 1'b1; memtoregW = 1'b0;
    aluoutW = v; writeregW = r;
  endtask

  // Watchdog: the directed sequence is short; this only guards against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    idle();
    validS = 1'b0;
    ra1D = 5'd0; ra2D = 5'd0;
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;

    // Reset state on all addresses, both ports.
    for (int a = 0; a < 32; a++) begin
      ra1D = a[4:0];
      ra2D = 5'(31 - a);
      expect_val(SEL_RD1, 32'h0, "reset_rd1");
      expect_val(SEL_RD2, 32'h0, "reset_rd2");
      expect_val(SEL_CNT, 32'h0, "reset_cnt");
      cyc();
    end

    // Write x5 with same-cycle bypass, then read it back from storage.
    wr(5'd5, 32'h1234_5678);
    ra1D = 5'd5; ra2D = 5'd5;
    expect_val(SEL_RD1, 32'h1234_5678, "bypass_rd1");
    expect_val(SEL_RD2, 32'h1234_5678, "bypass_rd2");
    expect_val(SEL_RES, 32'h1234_5678, "alu_result");
    expect_val(SEL_CNT, 32'h0, "cnt_before_edge");
    cyc();
    idle();
    expect_val(SEL_RD1, 32'h1234_5678, "stored_x5");
    expect_val(SEL_CNT, 32'h1, "cnt_after_first");
    cyc();

    // Load result aimed at x0: selected but discarded, still retires.
    validW = 1'b1; regwriteW = 1'b1; memtoregW = 1'b1;
    readdataW = 32'hDEAD_BEEF; aluoutW = 32'h0; writeregW = 5'd0;
    ra1D = 5'd0; ra2D = 5'd0;
    expect_val(SEL_RES, 32'hDEAD_BEEF, "mem_result");
    expect_val(SEL_RD1, 32'h0, "x0_during_rd1");
    expect_val(SEL_RD2, 32'h0, "x0_during_rd2");
    cyc();
    idle();
    expect_val(SEL_RD1, 32'h0, "x0_after_rd1");
    expect_val(SEL_RD2, 32'h0, "x0_after_rd2");
    expect_val(SEL_CNT, 32'h2, "cnt_x0_write");
    cyc();

    // Three bubbles with write intent: no write, no bypass, no count.
    for (int i = 0; i < 3; i++) begin
      validW = 1'b0; regwriteW = 1'b1; writeregW = 5'd7; aluoutW = 32'h0000_00FF;
      ra1D = 5'd7;
      expect_val(SEL_RES, 32'h0000_00FF, "bubble_result");
      expect_val(SEL_RD1, 32'h0, "bubble_no_bypass");
      expect_val(SEL_CNT, 32'h2, "bubble_cnt");
      cyc();
    end
    idle();
    expect_val(SEL_RD1, 32'h0, "bubble_x7");
    expect_val(SEL_CNT, 32'h2, "bubble_cnt_after");
    cyc();

    // Stored read on one port while the other sees a bypass.
    wr(5'd3, 32'h0BAD_F00D);
    cyc();
    wr(5'd4, 32'h5555_AAAA);
    ra1D = 5'd3; ra2D = 5'd4;
    expect_val(SEL_RD1, 32'h0BAD_F00D, "stored_x3");
    expect_val(SEL_RD2, 32'h5555_AAAA, "bypass_x4");
    expect_val(SEL_CNT, 32'h3, "cnt_three");
    cyc();
    // Store-like retire: regwriteW=0 must not bypass or write, but counts.
    validW = 1'b1; regwriteW = 1'b0; writeregW = 5'd3; aluoutW = 32'h0000_0001;
    ra1D = 5'd3; ra2D = 5'd4;
    expect_val(SEL_RD1, 32'h0BAD_F00D, "store_no_bypass");
    expect_val(SEL_RD2, 32'h5555_AAAA, "stored_x4");
    cyc();
    idle();
    expect_val(SEL_RD1, 32'h0BAD_F00D, "store_no_write");
    expect_val(SEL_CNT, 32'h5, "store_counts");
    cyc();

    // Write x9, then hit reset mid-cycle and check without a clock edge.
    wr(5'd9, 32'hAAAA_0001);
    cyc();
    idle();
    ra1D = 5'd9;
    expect_val(SEL_RD1, 32'hAAAA_0001, "stored_x9");
    expect_val(SEL_CNT, 32'h6, "cnt_before_reset");
    cyc();
    #1;
    reset = 1'b1;
    expect_val(SEL_RD1, 32'h0, "async_reset_rd");
    expect_val(SEL_CNT, 32'h0, "async_reset_cnt");
    cyc();
    // Write attempt while reset is held must be ignored.
    wr(5'd9, 32'h0000_0077);
    expect_val(SEL_RD1, 32'h0, "reset_hold_rd");
    cyc();
    reset = 1'b0;
    idle();
    expect_val(SEL_RD1, 32'h0, "x9_cleared");
    expect_val(SEL_CNT, 32'h0, "no_count_in_reset");
    cyc();

    // First edge after reset behaves normally.
    wr(5'd9, 32'h0000_0013);
    cyc();
    idle();
    expect_val(SEL_RD1, 32'h0000_0013, "post_reset_write");
    expect_val(SEL_CNT, 32'h1, "post_reset_cnt");
    cyc();

    // 4-bit counter instance: 15 retires, then wrap to 0, then 1.
    validS = 1'b1;
    repeat (15) cyc();
    validS = 1'b0;
    expect_val(SEL_SMALL, 32'hF, "small_cnt_max");
    cyc();
    validS = 1'b1;
    cyc();
    validS = 1'b0;
    expect_val(SEL_SMALL, 32'h0, "small_cnt_wrap");
    cyc();
    validS = 1'b1;
    cyc();
    validS = 1'b0;
    expect_val(SEL_SMALL, 32'h1, "small_cnt_after_wrap");

    // Let the monitor drain, then confirm nothing was left unchecked.
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback result and commits it to the architectural register file.
- Serves the two decode-stage read ports, with same-cycle write-through bypass.
- Maintains a retired-instruction counter for performance and debug.

Parameters:
DW, 32, data width of registers and result
NREGS, 32, number of architectural registers
AW, 5, register address width (log2 NREGS)
CNT_W, 32, retired-instruction counter width

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
validW  input  1  WB stage holds a real instruction (0 = bubble)
instrW  input  32  instruction word in WB, used for trace only
regwriteW  input  1  instruction writes a register
memtoregW  input  1  1 = result from readdataW, 0 = from aluoutW
aluoutW  input  DW  ALU result
readdataW  input  DW  load data
writeregW  input  AW  destination register
ra1D  input  AW  decode read address 1
ra2D  input  AW  decode read address 2
rd1D  output  DW  read data 1
rd2D  output  DW  read data 2
resultW  output  DW  selected writeback value, fed to forwarding muxes
retired_cnt  output  CNT_W  count of retired instructions

Behaviour:
- resultW is combinational: memtoregW ? readdataW : aluoutW. It is valid regardless of validW.
- Write enable: we = validW & regwriteW & (writeregW != 0).
- On posedge clk with we=1, rf[writeregW] <= resultW.
- Writes to register 0 are discarded. Register 0 always reads 0.
- Read ports are combinational, and each port applies this priority:
  - if raND == 0, rdND = 0;
  - else if we=1 and writeregW == raND, rdND = resultW (write-through bypass, same cycle);
  - else rdND = rf[raND].
- The bypass gives decode the new value in the same cycle the WB write happens, so no extra stall is needed.
- Both ports may address the same register; both get identical data.
- Retire counter: on posedge clk with validW=1, retired_cnt <= retired_cnt + 1, wrapping modulo 2^CNT_W.
  - Bubbles (validW=0) do not count.
  - Instructions with regwriteW=0 (stores, branches) do count.
- Reset (asynchronous, any time, including mid-stream):
  - all rf entries go to 0 and retired_cnt goes to 0 immediately;
  - rd1D/rd2D read 0 while reset is high;
  - no write occurs on a clock edge while reset is high.
- First edge after reset deassertion behaves normally.
- A writeregW address of NREGS or above cannot occur when NREGS = 2^AW; the block performs no range check.
- No outputs are registered beyond the rf array and the counter. Read latency is 0 cycles; write latency is 1 edge.

Optional Feature:
- Macro: WB_TRACE_EN.
- Defined: on each posedge clk with validW=1 and reset low, the simulator prints instrW and retired_cnt. When we=1, the print also includes writeregW and resultW. Bubbles print nothing.
- Not defined: no display statements are compiled. Functional behaviour is identical.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every rd = 0 and retired_cnt = 0.
- validW=1, regwriteW=1, memtoregW=0, aluoutW=0x1234_5678, writeregW=5, ra1D=5 in the same cycle -> rd1D = 0x1234_5678 before the edge (bypass). After the edge with the write inputs deasserted, rd1D still = 0x1234_5678 and retired_cnt = 1.
- memtoregW=1, readdataW=0xDEAD_BEEF, aluoutW=0x0, writeregW=0, validW=1, regwriteW=1 -> resultW = 0xDEAD_BEEF. Reading register 0 on both ports gives 0 during and after the edge. retired_cnt still increments.
- Three bubbles (validW=0, regwriteW=1, writeregW=7, aluoutW=0xFF) -> register 7 unchanged (0) and retired_cnt unchanged.
- Write 0xAAAA_0001 to register 9, then assert reset asynchronously mid-cycle -> rd on register 9 = 0 and retired_cnt = 0 without waiting for a clock edge.
- Force retired_cnt to 2^CNT_W-1 via CNT_W=4 with 15 retires, then 1 more retire -> retired_cnt = 0 (wrap).
